// File: rtl/demux_1_4_stream.sv
// rtl/demux_1_4_stream.sv - 1-to-4 stream demultiplexer with one-entry holding register per lane
module demux_1_4_stream #(
  parameter int DW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      sel,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*DW-1:0] out_data,
  output logic [7:0]      beat_cnt
);

  logic [3:0]    vq;
  logic [DW-1:0] dq [4];
  logic          accept;

  // The selected lane can take a beat when empty or draining in the same cycle.
  assign in_ready = !rst && (!vq[sel] || out_ready[sel]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vq       <= 4'b0000;
      beat_cnt <= 8'd0;
      for (int i = 0; i < 4; i++) dq[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (sel == 2'(i))) begin
          vq[i] <= 1'b1;
          dq[i] <= in_data;
        end else if (out_ready[i]) begin
          vq[i] <= 1'b0;
        end
      end
      if (accept) beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign out_valid = vq;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign out_data[g*DW +: DW] = dq[g];
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb/tb_demux_1_4_stream.sv - randomized and directed self-checking bench for demux_1_4_stream
module tb_demux_1_4_stream;
  localparam int DW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [1:0]      sel;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*DW-1:0] out_data;
  logic [7:0]      beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: what each lane holds and how many beats have been taken.
  bit      m_full [4];
  int      m_data [4];
  int      m_cnt;

  demux_1_4_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input int s, input int d, input logic [3:0] ordy);
    bit         rdy_exp;
    bit         take;
    logic [31:0] v_exp;
    logic [31:0] d_exp;
    rst       = r;
    in_valid  = iv;
    sel       = 2'(s);
    in_data   = DW'(d);
    out_ready = ordy;
    #1;
    rdy_exp = !r && (!m_full[s] || ordy[s]);
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    @(posedge clk);
    take = iv && rdy_exp;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0;
        m_data[i] = 0;
      end
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ordy[i]) m_full[i] = 0;
      if (take) begin
        m_full[s] = 1;
        m_data[s] = d % (1 << DW);
        m_cnt     = (m_cnt + 1) % 256;
      end
    end
    #1;
    v_exp = 0;
    d_exp = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_full[i]) v_exp = v_exp | (32'd1 << i);
      d_exp = d_exp | (32'(m_data[i]) << (i * DW));
    end
    check("out_valid", 32'(out_valid), v_exp);
    check("out_data", 32'(out_data), d_exp);
    check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0;
      m_data[i] = 0;
    end
    m_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 2'd0; out_ready = 4'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1, 1, 0, 3, 4'b0000);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_cnt", 32'(beat_cnt), 32'd0);

    // Routing: each lane shows its beat for exactly one cycle
    for (int i = 0; i < 4; i++) step(0, 1, i, i, 4'b1111);
    step(0, 0, 0, 0, 4'b1111);
    check("route_cnt", 32'(beat_cnt), 32'd4);
    check("route_empty", 32'(out_valid), 32'd0);

    // Backpressure on lane 2
    step(0, 1, 2, 2, 4'b0000);
    step(0, 1, 2, 1, 4'b0000);
    check("bp_stall", 32'(in_ready), 32'd0);
    step(0, 1, 2, 1, 4'b0100);
    check("bp_lane2", 32'(out_data[2*DW +: DW]), 32'd1);
    step(0, 0, 0, 0, 4'b0100);
    check("bp_cnt", 32'(beat_cnt), 32'd6);

    // Head-of-line block then redirect to lane 3
    step(0, 1, 1, 2, 4'b0000);
    step(0, 1, 1, 3, 4'b0000);
    step(0, 1, 1, 3, 4'b0000);
    check("hol_others", 32'(out_valid), 32'b0010);
    step(0, 1, 3, 3, 4'b0000);
    check("hol_lane3", 32'(out_valid), 32'b1010);
    step(0, 0, 0, 0, 4'b1111);

    // Simultaneous drain/load on lane 0
    step(0, 1, 0, 1, 4'b0001);
    for (int k = 0; k < 3; k++) step(0, 1, 0, (k + 2) % 4, 4'b0001);
    check("dl_valid", 32'(out_valid[0]), 32'd1);
    step(0, 0, 0, 0, 4'b1111);

    // Reset mid-operation: lanes 0 and 3 full, count 7
    step(1, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 1, 1, i, 4'b1111);
    step(0, 1, 0, 2, 4'b0000);
    step(0, 1, 3, 1, 4'b0000);
    check("pre_rst_cnt", 32'(beat_cnt), 32'd7);
    step(1, 1, 2, 3, 4'b0000);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_cnt", 32'(beat_cnt), 32'd0);
    // First cycle after reset accepts
    step(0, 1, 1, 2, 4'b0000);
    check("post_rst_cnt", 32'(beat_cnt), 32'd1);

    // Counter wrap
    step(1, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 256; i++) step(0, 1, i % 4, i, 4'b1111);
    check("wrap_256", 32'(beat_cnt), 32'd0);
    step(0, 1, 0, 1, 4'b1111);
    check("wrap_257", 32'(beat_cnt), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 The block SHALL have one parameter: DW, default 2, data width of every lane in bits.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, upstream beat present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block accepts beat this cycle.
REQ-007 The block SHALL have port in_data, input, DW bits, upstream payload.
REQ-008 The block SHALL have port sel, input, 2 bits, destination lane index 0..3.
REQ-009 The block SHALL have port out_valid, output, 4 bits, bit i set when lane i holds a beat.
REQ-010 The block SHALL have port out_ready, input, 4 bits, bit i set when lane i consumer takes its beat.
REQ-011 The block SHALL have port out_data, output, 4*DW bits, lane i payload in bits [i*DW +: DW].
REQ-012 The block SHALL have port beat_cnt, output, 8 bits, count of beats accepted since reset.

Function
REQ-013 Each lane i SHALL own a one-entry holding register: valid flag vq[i] and payload dq[i].
REQ-014 out_valid[i] SHALL equal vq[i], and out_data lane i SHALL equal dq[i], both driven directly from registers.
REQ-015 in_ready SHALL be combinational: in_ready = !rst & (!vq[sel] | out_ready[sel]).
REQ-016 An input handshake (accept) SHALL occur in a cycle where in_valid & in_ready are both 1.
REQ-017 On accept at edge N, dq[sel] SHALL load in_data and vq[sel] SHALL be set; the beat SHALL be visible on lane sel after edge N, giving a one-cycle latency.
REQ-018 An output handshake on lane i SHALL occur in a cycle where vq[i] & out_ready[i] are both 1; if lane i is not loaded in that cycle, vq[i] SHALL clear at the edge.
REQ-019 Drain and load of the same lane in one cycle SHALL leave vq = 1 with the new payload, so the lane sustains one beat per cycle.
REQ-020 Drain of lane j and load of lane k (j != k) in one cycle SHALL both take effect independently.
REQ-021 Lanes other than sel SHALL never be loaded, and dq[i] SHALL hold its value whenever lane i is not loaded.
REQ-022 A full, non-draining sel lane SHALL stall input (in_ready = 0) even when other lanes are empty; there is no reordering and no bypass.
REQ-023 sel SHALL be used only in the cycle of the beat; changing sel while stalled SHALL redirect the pending beat to the new sel lane under REQ-015.
REQ-024 in_valid = 0 SHALL cause no state change other than drains.
REQ-025 out_ready[i] asserted while vq[i] = 0 SHALL have no effect.
REQ-026 beat_cnt SHALL increment by 1 on each accept, and SHALL wrap 255 -> 0 with no flag.

Reset
REQ-027 While rst = 1 at a rising edge, vq SHALL become 4'b0000, every dq SHALL become 0, and beat_cnt SHALL become 0.
REQ-028 While rst = 1, in_ready SHALL be 0, and any in_valid in that cycle SHALL be discarded and not counted.
REQ-029 Reset asserted mid-stream SHALL drop all held beats, with no output handshake implied.
REQ-030 After rst deasserts, the first accept SHALL be possible in the first cycle with rst = 0.

Verification
REQ-031 Routing: DW=2, out_ready=4'b1111, send (sel,data) = (0,00),(1,01),(2,10),(3,11) on consecutive cycles -> each lane i shows data i for exactly one cycle, one cycle after its accept; beat_cnt = 4.
REQ-032 Backpressure: out_ready=0, send (2,10) then (2,01) -> first beat accepted, in_ready = 0 for the second; raise out_ready[2] -> lane 2 shows 10, then 01; beat_cnt ends at 2.
REQ-033 Head-of-line block: lane 1 full with out_ready[1]=0, in_valid with sel=1 -> in_ready = 0 and lanes 0/2/3 stay empty; switch sel to 3 -> accept the next cycle, lane 3 loaded.
REQ-034 Simultaneous drain/load: lane 0 full, out_ready[0]=1, in_valid sel=0 data=11 for 3 cycles -> in_ready stays 1, out_valid[0] stays 1, payload updates every cycle.
REQ-035 Reset mid-operation: lanes 0 and 3 full, beat_cnt = 7, pulse rst for 1 cycle with in_valid=1 -> out_valid = 0000, out_data = 0, beat_cnt = 0, and the beat is not captured.
REQ-036 Wrap: perform 256 accepts -> beat_cnt reads 0 after the 256th and 1 after the 257th.
